// File: rtl/rpn_pkg.sv
// Shared RPN datapath definitions: stack command codes, entry next-value selects
// and the default operand width used by the stack, ALU and display.
package rpn_pkg;

  localparam int RPN_WIDTH = 16;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_PUSH   = 3'd1,
    CMD_POP    = 3'd2,
    CMD_SWAP   = 3'd3,
    CMD_REDUCE = 3'd4,
    CMD_DUP    = 3'd5,
    CMD_CLEAR  = 3'd6,
    CMD_RSVD   = 3'd7
  } cmd_t;

  // "above" is the shallower neighbour (index-1), "below" the deeper one (index+1)
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_ABOVE = 2'd1,
    SEL_BELOW = 2'd2,
    SEL_LOAD  = 2'd3
  } sel_t;

endpackage

// File: rtl/rpn_stack_entry.sv
// One stack slot: WIDTH-bit register choosing between hold, the neighbour above,
// the neighbour below, or the din operand; clr forces the slot to zero.
module rpn_stack_entry
  import rpn_pkg::*;
#(
  parameter int WIDTH = RPN_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] below,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_ABOVE: q <= above;
        SEL_BELOW: q <= below;
        SEL_LOAD:  q <= din;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/rpn_operand_stack.sv
// LIFO operand stack for the RPN datapath; exposes top/next to the ALU.
// Build option RPN_STACK_WRAP_EN: PUSH/DUP on a full stack drops the bottom entry.
module rpn_operand_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = RPN_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] q     [DEPTH];
  logic [WIDTH-1:0] above [DEPTH];
  logic [WIDTH-1:0] below [DEPTH];
  logic [1:0]       sel   [DEPTH];

  logic          do_push, do_dup, do_pop, do_swap, do_reduce, do_clear;
  logic [CW-1:0] count_nxt;
  logic          err_nxt;
  logic          lt_two;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign lt_two = (count < CW'(2));

  always_comb begin
    do_push   = 1'b0;
    do_dup    = 1'b0;
    do_pop    = 1'b0;
    do_swap   = 1'b0;
    do_reduce = 1'b0;
    do_clear  = 1'b0;
    count_nxt = count;
    err_nxt   = err;
    if (cmd_valid) begin
      case (cmd_t'(cmd))
        CMD_PUSH, CMD_DUP: begin
          if (cmd_t'(cmd) == CMD_DUP && empty) begin
            err_nxt = 1'b1;
          end else if (full) begin
`ifdef RPN_STACK_WRAP_EN
            do_push = (cmd_t'(cmd) == CMD_PUSH);
            do_dup  = (cmd_t'(cmd) == CMD_DUP);
`else
            err_nxt = 1'b1;
`endif
          end else begin
            do_push   = (cmd_t'(cmd) == CMD_PUSH);
            do_dup    = (cmd_t'(cmd) == CMD_DUP);
            count_nxt = count + CW'(1);
          end
        end
        CMD_POP: begin
          if (empty) begin
            err_nxt = 1'b1;
          end else begin
            do_pop    = 1'b1;
            count_nxt = count - CW'(1);
          end
        end
        CMD_SWAP: begin
          if (lt_two) err_nxt = 1'b1;
          else        do_swap = 1'b1;
        end
        CMD_REDUCE: begin
          if (lt_two) begin
            err_nxt = 1'b1;
          end else begin
            do_reduce = 1'b1;
            count_nxt = count - CW'(1);
          end
        end
        CMD_CLEAR: begin
          do_clear  = 1'b1;
          count_nxt = '0;
          err_nxt   = 1'b0;
        end
        CMD_RSVD: err_nxt = 1'b1;
        default:  ;
      endcase
    end
  end

  // DUP shifts down like PUSH but slot 0 keeps its value, so slot 1 receives the copy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = SEL_HOLD;
      if (do_push)
        sel[i] = (i == 0) ? SEL_LOAD : SEL_ABOVE;
      else if (do_dup)
        sel[i] = (i == 0) ? SEL_HOLD : SEL_ABOVE;
      else if (do_pop)
        sel[i] = SEL_BELOW;
      else if (do_swap)
        sel[i] = (i == 0) ? SEL_BELOW : ((i == 1) ? SEL_ABOVE : SEL_HOLD);
      else if (do_reduce)
        sel[i] = (i == 0) ? SEL_LOAD : SEL_BELOW;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (i == 0) begin : g_first
      assign above[i] = '0;
    end else begin : g_above
      assign above[i] = q[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign below[i] = '0;
    end else begin : g_below
      assign below[i] = q[i+1];
    end

    rpn_stack_entry #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .clr   (reset | do_clear),
      .sel   (sel[i]),
      .above (above[i]),
      .below (below[i]),
      .din   (din),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  assign top  = empty  ? '0 : q[0];
  assign next = lt_two ? '0 : q[1];

endmodule
